// File: rtl/ascon_perm_scheduler.sv
// ascon_perm_scheduler: control FSM sequencing the ASCON state datapath
// through INIT (load, p^a, key XOR) and stand-alone p^a / p^b calls.
// Ports: clk, rst (async active-high); cmd_valid/cmd_ready/cmd_op/sel_type
// command side; dp_load/dp_iv/dp_round_en/dp_rc/dp_key_xor datapath
// strobes; done_valid/done_ready completion handshake; busy.
// Optional macro ASCON_SCHED_ABORT_EN adds input abort, which cancels an
// operation in LOAD/ROUND/KEYX and returns to IDLE without done_valid.
module ascon_perm_scheduler #(
  parameter int ROUNDS_A = 12,
  parameter int RC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [1:0]      sel_type,
  output logic            dp_load,
  output logic [63:0]     dp_iv,
  output logic            dp_round_en,
  output logic [RC_W-1:0] dp_rc,
  output logic            dp_key_xor,
  output logic            done_valid,
  input  logic            done_ready,
`ifdef ASCON_SCHED_ABORT_EN
  input  logic            abort,
`endif
  output logic            busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_ROUND = 3'd2;
  localparam logic [2:0] S_KEYX  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] OP_INIT   = 2'd0;
  localparam logic [1:0] OP_PERM_A = 2'd1;
  localparam logic [1:0] OP_PERM_B = 2'd2;
  localparam logic [1:0] OP_RSVD   = 2'd3;

  // First round index of p^a; the schedule always ends at index 11.
  localparam logic [3:0] A_START = 4'(12 - ROUNDS_A);
  localparam logic [3:0] LAST_IDX = 4'd11;

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [3:0] rnd;
  logic [1:0] op_q;
  logic [1:0] sel_q;
  logic       accept;
  logic       last_round;
  logic       keyed;
  logic       abort_hit;
  logic [7:0] rc8;

  function automatic logic [3:0] start_idx(
    input logic [1:0] op,
    input logic [1:0] sel
  );
    logic [3:0] s;
    s = A_START;
    if (op == OP_PERM_B) begin
      unique case (sel)
        2'd0:    s = 4'd6;
        2'd1:    s = 4'd4;
        default: s = 4'd0;
      endcase
    end
    return s;
  endfunction

  function automatic logic [63:0] iv_of(input logic [1:0] sel);
    logic [63:0] v;
    unique case (sel)
      2'd0:    v = 64'h80400C0600000000;
      2'd1:    v = 64'h80800C0800000000;
      2'd2:    v = 64'h00400C0000000100;
      default: v = 64'h00400C0000000000;
    endcase
    return v;
  endfunction

  assign accept     = cmd_valid && (state == S_IDLE);
  assign last_round = (rnd == LAST_IDX);
  // Only the AEAD variants carry a key to fold back in after p^a.
  assign keyed      = (op_q == OP_INIT) && !sel_q[1];

`ifdef ASCON_SCHED_ABORT_EN
  assign abort_hit = abort &&
    ((state == S_LOAD) || (state == S_ROUND) || (state == S_KEYX));
`else
  assign abort_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          unique case (cmd_op)
            OP_INIT:   state_nxt = S_LOAD;
            OP_PERM_A: state_nxt = S_ROUND;
            OP_PERM_B: state_nxt = S_ROUND;
            default:   state_nxt = S_DONE;
          endcase
        end
      end
      S_LOAD:  state_nxt = S_ROUND;
      S_ROUND: begin
        if (last_round) begin
          state_nxt = keyed ? S_KEYX : S_DONE;
        end
      end
      S_KEYX:  state_nxt = S_DONE;
      S_DONE:  begin
        if (done_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort_hit) begin
      state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      rnd   <= 4'd0;
      op_q  <= 2'd0;
      sel_q <= 2'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q  <= cmd_op;
        sel_q <= sel_type;
        rnd   <= start_idx(cmd_op, sel_type);
      end else if (state_nxt == S_IDLE) begin
        rnd <= 4'd0;
      end else if ((state == S_ROUND) && !last_round) begin
        rnd <= rnd + 4'd1;
      end
    end
  end

  // rc_i = F0 - i*0F mod 256, gated to zero outside ROUND.
  always_comb begin
    rc8 = 8'h00;
    if (state == S_ROUND) begin
      rc8 = 8'hF0 - ({4'd0, rnd} * 8'h0F);
    end
  end

  assign dp_rc       = RC_W'(rc8);
  assign dp_load     = (state == S_LOAD);
  assign dp_round_en = (state == S_ROUND);
  assign dp_key_xor  = (state == S_KEYX);
  assign done_valid  = (state == S_DONE);
  assign cmd_ready   = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign dp_iv       = (state == S_IDLE) ? 64'd0 : iv_of(sel_q);

  logic unused_op;
  assign unused_op = ^{op_q == OP_RSVD, op_q == OP_PERM_A};

endmodule

// File: tb/tb_ascon_perm_scheduler.sv
// tb_ascon_perm_scheduler: scoreboard bench for ascon_perm_scheduler.
// Stimulus pushes per-cycle expected outputs; a monitor pops and compares.
module tb_ascon_perm_scheduler;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [1:0]  sel_type;
  logic        dp_load;
  logic [63:0] dp_iv;
  logic        dp_round_en;
  logic [7:0]  dp_rc;
  logic        dp_key_xor;
  logic        done_valid;
  logic        done_ready;
  logic        busy;
`ifdef ASCON_SCHED_ABORT_EN
  logic        abort;
`endif

  ascon_perm_scheduler #(.ROUNDS_A(12), .RC_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .sel_type(sel_type),
    .dp_load(dp_load),
    .dp_iv(dp_iv),
    .dp_round_en(dp_round_en),
    .dp_rc(dp_rc),
    .dp_key_xor(dp_key_xor),
    .done_valid(done_valid),
    .done_ready(done_ready),
`ifdef ASCON_SCHED_ABORT_EN
    .abort(abort),
`endif
    .busy(busy)
  );

  typedef struct {
    int          cyc;
    logic        ld;
    logic        rn;
    logic        kx;
    logic        dn;
    logic [7:0]  rc;
    logic [63:0] iv;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  logic [7:0]  rc_tab [12] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                               8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};
  logic [63:0] iv_tab [4]  = '{64'h80400C0600000000, 64'h80800C0800000000,
                               64'h00400C0000000100, 64'h00400C0000000000};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (dp_load || dp_round_en || dp_key_xor || done_valid || busy ||
        !cmd_ready || dp_rc != 8'd0 || dp_iv != 64'd0) begin
      if (sb.size() == 0) begin
        chk("unexpected_activity", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("cycle", 64'(cyc), 64'(e.cyc));
        chk("dp_load", dp_load, e.ld);
        chk("dp_round_en", dp_round_en, e.rn);
        chk("dp_key_xor", dp_key_xor, e.kx);
        chk("done_valid", done_valid, e.dn);
        chk("dp_rc", dp_rc, e.rc);
        chk("dp_iv", dp_iv, e.iv);
        chk("busy", busy, 1);
        chk("cmd_ready", cmd_ready, 0);
      end
    end
  end

  function automatic void push(int c, int rel, int lim, logic ld, logic rn,
                               logic kx, logic dn, logic [7:0] rc,
                               logic [63:0] iv);
    exp_t e;
    if (rel <= lim) begin
      e.cyc = c; e.ld = ld; e.rn = rn; e.kx = kx; e.dn = dn;
      e.rc = rc; e.iv = iv;
      sb.push_back(e);
    end
  endfunction

  task automatic check_idle(string nm);
    chk({nm, "_cmd_ready"}, cmd_ready, 1);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_strobes"},
        {dp_load, dp_round_en, dp_key_xor, done_valid}, 0);
    chk({nm, "_rc_iv"}, {dp_rc, dp_iv} != 0, 0);
  endtask

  // mode 0: run to DONE; 1: reset at rel cycle lim+1; 2: abort at rel lim.
  task automatic run_cmd(input logic [1:0] op, input logic [1:0] sel,
                         input int hold, input bit noise,
                         input int mode, input int lim_in);
    int c0, k, n, dc, lim;
    logic [63:0] iv;
    lim = (mode == 0) ? 1000 : lim_in;
    iv = iv_tab[sel];
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; sel_type = sel;
    c0 = cyc;
    chk("accept_cmd_ready", cmd_ready, 1);
    k = 1;
    if (op == 2'd0) begin
      push(c0 + k, k, lim, 1, 0, 0, 0, 8'h00, iv);
      k++;
    end
    if (op != 2'd3) begin
      n = (op == 2'd2) ? ((sel == 2'd0) ? 6 : (sel == 2'd1) ? 8 : 12) : 12;
      for (int r = 12 - n; r < 12; r++) begin
        push(c0 + k, k, lim, 0, 1, 0, 0, rc_tab[r], iv);
        k++;
      end
    end
    if (op == 2'd0 && sel < 2'd2) begin
      push(c0 + k, k, lim, 0, 0, 1, 0, 8'h00, iv);
      k++;
    end
    dc = c0 + k;
    for (int h = 0; h <= hold; h++) begin
      push(dc + h, k + h, lim, 0, 0, 0, 1, 8'h00, iv);
    end
    @(posedge clk); #1;
    if (noise) begin
      cmd_op = ~op; sel_type = ~sel;
    end else begin
      cmd_valid = 1'b0;
    end
    if (mode == 1) begin
      repeat (lim) @(posedge clk);
      #1 rst = 1'b1;
      #1 check_idle("rst_mid_op");
      @(posedge clk); #1 rst = 1'b0;
      cmd_valid = 1'b0;
    end else if (mode == 2) begin
`ifdef ASCON_SCHED_ABORT_EN
      repeat (lim - 1) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      cmd_valid = 1'b0;
      check_idle("after_abort");
`endif
    end else begin
      repeat (dc + hold - (c0 + 1)) @(posedge clk);
      #1;
      if (hold > 0) chk("done_held_ready", cmd_ready, 0);
      done_ready = 1'b1; cmd_valid = 1'b0;
      @(posedge clk); #1 done_ready = 1'b0;
      check_idle("after_done");
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; sel_type = 2'd0;
    done_ready = 1'b0;
`ifdef ASCON_SCHED_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 check_idle("reset");
    rst = 1'b0;
    run_cmd(2'd0, 2'd0, 0, 0, 0, 0);
    run_cmd(2'd0, 2'd2, 0, 0, 0, 0);
    run_cmd(2'd2, 2'd0, 0, 0, 0, 0);
    run_cmd(2'd2, 2'd1, 0, 0, 0, 0);
    run_cmd(2'd2, 2'd3, 0, 0, 0, 0);
    run_cmd(2'd1, 2'd3, 0, 0, 0, 0);
    run_cmd(2'd0, 2'd1, 5, 1, 0, 0);
    run_cmd(2'd3, 2'd2, 0, 0, 0, 0);
    run_cmd(2'd0, 2'd0, 0, 0, 1, 5);
    run_cmd(2'd0, 2'd0, 2, 0, 0, 0);
`ifdef ASCON_SCHED_ABORT_EN
    run_cmd(2'd0, 2'd0, 0, 0, 2, 4);
    run_cmd(2'd3, 2'd1, 0, 0, 0, 0);
`endif
    repeat (3) @(posedge clk);
    #1 chk("scoreboard_empty", 64'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ascon_perm_scheduler.md
Name: ascon_perm_scheduler

Overview:
- Control FSM that sequences the ASCON state datapath: initialization (IV||K||N load, p^a, key XOR) and stand-alone p^a / p^b permutation calls.
- Drives a one-round-per-cycle permutation datapath with load, round-enable, round-constant and key-XOR strobes.
- Sits between the mode-level top controller (command side) and the state register / round logic (datapath side).
- Uses a valid/ready command handshake and a valid/ready completion handshake.

Parameters:
- ROUNDS_A, 12, rounds for p^a (init/final); legal range 1..12.
- RC_W, 8, round-constant width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  0=INIT, 1=PERM_A, 2=PERM_B, 3=reserved.
- sel_type  in  2  0=Ascon-128, 1=Ascon-128a, 2=Hash, 3=Xof; sampled on accept.
- dp_load  out  1  load {iv, key, nonce} (keyed) or {iv, 0} (hash/xof) into x0..x4.
- dp_iv  out  64  IV for latched sel_type.
- dp_round_en  out  1  apply one permutation round this cycle.
- dp_rc  out  RC_W  round constant for the current round.
- dp_key_xor  out  1  XOR 0^192||K into state (x3,x4).
- done_valid  out  1  operation complete; state valid.
- done_ready  in  1  consumer acknowledges.
- busy  out  1  high in every state except IDLE.

Behaviour:
- States: IDLE, LOAD, ROUND, KEYX, DONE.
- Reset: state=IDLE, round counter=0, sel/op latches=0. All outputs 0 except cmd_ready=1.
- IDLE:
  - cmd_valid&&cmd_ready accepts the command; cmd_op and sel_type are latched.
  - INIT -> LOAD. PERM_A/PERM_B -> ROUND. Reserved op -> DONE directly, with no datapath strobes.
- LOAD: dp_load=1 for exactly one cycle -> ROUND.
- ROUND:
  - dp_round_en=1 for N consecutive cycles.
  - N = ROUNDS_A for INIT/PERM_A.
  - N for PERM_B depends on latched sel_type: Ascon-128 = 6, Ascon-128a = 8, Hash/Xof = 12.
  - Round index i runs from 12-N to 11.
  - dp_rc = 8'hF0 - i*8'h0F, computed modulo 256. Sequence for N=12: F0,E1,D2,C3,B4,A5,96,87,78,69,5A,4B.
  - Last round of INIT with keyed sel (0/1) -> KEYX. All other last rounds -> DONE.
- KEYX: dp_key_xor=1 for one cycle -> DONE.
- DONE:
  - done_valid=1, held until done_ready.
  - done_valid&&done_ready -> IDLE on the next edge; cmd_ready rises that edge.
  - No back-to-back accept in the same cycle as done handshake.
- dp_iv values:
  - sel 0 = 64'h80400C0600000000
  - sel 1 = 64'h80800C0800000000
  - sel 2 = 64'h00400C0000000100
  - sel 3 = 64'h00400C0000000000
  - dp_iv is 0 in IDLE.
- Latency, cmd accept edge to done_valid:
  - INIT keyed: 1 + 12 + 1 = 14 cycles.
  - INIT hash: 13 cycles.
  - PERM_B with sel 0: 6 cycles.
- cmd_valid outside IDLE is ignored. sel_type/cmd_op changes after accept have no effect.
- Strobes are mutually exclusive; at most one of dp_load/dp_round_en/dp_key_xor is high in any cycle.
- dp_rc=0 whenever dp_round_en=0.
- rst asserted mid-operation: immediate return to reset values, no done_valid.

Optional Feature:
- ASCON_SCHED_ABORT_EN: adds input abort (1 bit).
- Abort high in LOAD/ROUND/KEYX forces IDLE on the next edge: no further strobes, no done_valid. abort is ignored in IDLE and DONE.
- Without the macro: no port; every accepted command runs to DONE.

Test Plan:
- Reset then INIT, sel 0 -> dp_load at cycle 1, dp_iv=80400C0600000000. dp_round_en cycles 2..13 with rc F0..4B. dp_key_xor at cycle 14. done_valid at cycle 15.
- INIT, sel 2 -> 12 rounds, no dp_key_xor. done_valid 13 cycles after accept. dp_iv=00400C0000000100.
- PERM_B with sel 0, then sel 1 -> 6 rounds rc 96,87,78,69,5A,4B. Then 8 rounds rc B4..4B.
- done_ready held low 5 cycles -> done_valid stays 1, cmd_ready 0, cmd_valid ignored. After the done_ready pulse, cmd_ready=1 next cycle.
- rst pulse during round 5 of INIT -> all outputs 0, cmd_ready=1 immediately. A new INIT then runs the full 15-cycle sequence.
- With ASCON_SCHED_ABORT_EN: abort at round 3 -> IDLE next cycle, no done_valid, no dp_key_xor. Reserved cmd_op=3 -> done_valid 1 cycle after accept, no strobes.
